// File: rtl/rgb_pwm_decoder8.sv
`timescale 1ns/1ps
// Purpose : recovers 8-bit R/G/B codes from three PWM lines by counting active cycles per 256-cycle frame.
// Latency : codes and valid_o appear SYNC_STAGES+256 clocks after the raw sync_i pulse that opened the window.
// Backpressure: none; valid_o is a 1-cycle strobe and outputs hold until the next completed window.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   an                       line polarity (1 = active-low anode lines, 0 = active-high cathode lines)
//   sync_i                   generator frame-start pulse, one cycle every 256 clocks
//   r_i, g_i, b_i            PWM lines
//   rcolor_o/gcolor_o/bcolor_o  recovered codes (0..255, full-frame active saturates to 255)
//   valid_o, changed_o       update strobe, and "some code differs from the held value" with it
//   locked_o                 frames are arriving with a consistent 256-cycle period
module rgb_pwm_decoder8 #(
    parameter int SYNC_STAGES = 2,
    parameter bit USE_SYNC    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       an,
    input  logic       sync_i,
    input  logic       r_i,
    input  logic       g_i,
    input  logic       b_i,
    output logic [7:0] rcolor_o,
    output logic [7:0] gcolor_o,
    output logic [7:0] bcolor_o,
    output logic       valid_o,
    output logic       changed_o,
    output logic       locked_o
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] MEASURE   = 1'b1;
    // Free-running mode skips the wait for sync entirely.
    localparam logic [0:0] RST_STATE = USE_SYNC ? IDLE : MEASURE;

    // Sync pulse and data share one synchronizer chain so they stay cycle-aligned.
    // Bit order per stage: {sync, b, g, r}.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  synced;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {sync_i, b_i, g_i, r_i};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    logic sync_s;
    logic smp_r, smp_g, smp_b;

    assign sync_s = USE_SYNC ? synced[3] : 1'b0;
    assign smp_r  = synced[0] ^ an;
    assign smp_g  = synced[1] ^ an;
    assign smp_b  = synced[2] ^ an;

    logic [0:0] state;
    logic [7:0] win_cnt;
    logic [8:0] acc_r, acc_g, acc_b;
    logic [8:0] acc_r_nxt, acc_g_nxt, acc_b_nxt;
    logic [7:0] code_r, code_g, code_b;

    // 9-bit accumulators can reach 256 (line stuck active); that clamps to 255.
    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    assign acc_r_nxt = acc_r + {8'd0, smp_r};
    assign acc_g_nxt = acc_g + {8'd0, smp_g};
    assign acc_b_nxt = acc_b + {8'd0, smp_b};
    assign code_r    = sat8(acc_r_nxt);
    assign code_g    = sat8(acc_g_nxt);
    assign code_b    = sat8(acc_b_nxt);

    // Window control decisions for this cycle.
    logic do_start;   // open a window with this cycle's sample
    logic do_idle;    // expected sync missing: drop back to IDLE
    logic do_finish;  // last cycle of a window: publish codes
    logic lock_loss;

    always_comb begin
        do_start  = 1'b0;
        do_idle   = 1'b0;
        do_finish = 1'b0;
        lock_loss = 1'b0;
        if (state == IDLE) begin
            do_start = sync_s;
        end else begin
            if (sync_s && (win_cnt != 8'd0)) begin
                // Misaligned sync: the partial window is thrown away and
                // measurement restarts right here.
                do_start  = 1'b1;
                lock_loss = 1'b1;
            end else if (win_cnt == 8'd0) begin
                if (sync_s || !USE_SYNC) begin
                    do_start = 1'b1;
                end else begin
                    do_idle   = 1'b1;
                    lock_loss = 1'b1;
                end
            end else if (win_cnt == 8'd255) begin
                do_finish = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            win_cnt   <= 8'd0;
            acc_r     <= 9'd0;
            acc_g     <= 9'd0;
            acc_b     <= 9'd0;
            rcolor_o  <= 8'd0;
            gcolor_o  <= 8'd0;
            bcolor_o  <= 8'd0;
            valid_o   <= 1'b0;
            changed_o <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            changed_o <= 1'b0;
            if (do_start) begin
                state   <= MEASURE;
                win_cnt <= 8'd1;
                acc_r   <= {8'd0, smp_r};
                acc_g   <= {8'd0, smp_g};
                acc_b   <= {8'd0, smp_b};
                if (lock_loss) begin
                    locked_o <= 1'b0;
                end
            end else if (do_idle) begin
                state    <= IDLE;
                locked_o <= 1'b0;
            end else if (do_finish) begin
                rcolor_o  <= code_r;
                gcolor_o  <= code_g;
                bcolor_o  <= code_b;
                valid_o   <= 1'b1;
                changed_o <= (code_r != rcolor_o) || (code_g != gcolor_o) ||
                             (code_b != bcolor_o);
                locked_o  <= 1'b1;
                win_cnt   <= 8'd0;
            end else if (state == MEASURE) begin
                acc_r   <= acc_r_nxt;
                acc_g   <= acc_g_nxt;
                acc_b   <= acc_b_nxt;
                win_cnt <= win_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_decoder8.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for rgb_pwm_decoder8 (sync-aligned mode, two-stage synchronizer).
// Latency : expects each window's codes SYNC_STAGES+256 clocks after its sync_i pulse.
// Backpressure: n/a; every valid_o pulse is matched against a queue of expected windows.
module tb_rgb_pwm_decoder8;

    localparam int S      = 2;
    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       an;
    logic       sync_i;
    logic       r_i, g_i, b_i;
    logic [7:0] rcolor_o, gcolor_o, bcolor_o;
    logic       valid_o, changed_o, locked_o;

    rgb_pwm_decoder8 #(.SYNC_STAGES(S), .USE_SYNC(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .an        (an),
        .sync_i    (sync_i),
        .r_i       (r_i),
        .g_i       (g_i),
        .b_i       (b_i),
        .rcolor_o  (rcolor_o),
        .gcolor_o  (gcolor_o),
        .bcolor_o  (bcolor_o),
        .valid_o   (valid_o),
        .changed_o (changed_o),
        .locked_o  (locked_o)
    );

    always #(PERIOD/2) clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       an;
        int         rd, gd, bd;    // electrical high cycles per frame (256 = always high)
        logic [7:0] er, eg, eb;
        logic       chg;
    } vec_t;

    typedef struct {
        logic [7:0] r, g, b;
        logic       chg;
        longint     t;             // time the sync pulse was driven
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line is high for cycles 1..duty after the sync cycle; 256 means stuck high.
    function automatic logic line_lvl(input int duty, input int i);
        return (duty >= 256) || (i >= 1 && i <= duty);
    endfunction

    // Drives len cycles of one generator frame. The polarity input is switched
    // S cycles into the frame so it lines up with the synchronized line data.
    task automatic drive_frame(input logic sync_first, input logic an_v,
                               input int rd, input int gd, input int bd,
                               input int len, input logic expect_v,
                               input logic [7:0] er, input logic [7:0] eg,
                               input logic [7:0] eb, input logic echg);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            sync_i = sync_first && (i == 0);
            if (i == S) an = an_v;
            r_i = line_lvl(rd, i);
            g_i = line_lvl(gd, i);
            b_i = line_lvl(bd, i);
            if (sync_first && i == 0 && expect_v) begin
                e.r = er; e.g = eg; e.b = eb; e.chg = echg; e.t = longint'($time);
                sb.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from DUT updates.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_valid) check("valid_width", valid_o, 0);
            if (valid_o === 1'b1 && !prev_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got valid_o=1, expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("rcolor", rcolor_o, e.r);
                    check("gcolor", gcolor_o, e.g);
                    check("bcolor", bcolor_o, e.b);
                    check("changed", changed_o, e.chg);
                    check("locked_at_valid", locked_o, 1);
                    check("latency_clks", (longint'($time) - e.t) / PERIOD, S + 256);
                end
            end
            prev_valid = (valid_o === 1'b1);
        end
    end

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 100,   0, 256, 8'd100, 8'd0,   8'd255, 1'b1};
        vecs[1] = '{1'b0, 100,   0, 256, 8'd100, 8'd0,   8'd255, 1'b0};
        vecs[2] = '{1'b1, 100,   0, 256, 8'd156, 8'd255, 8'd0,   1'b1};
        vecs[3] = '{1'b0,  50,   0,   0, 8'd50,  8'd0,   8'd0,   1'b1};
        vecs[4] = '{1'b0,  50,   0,   0, 8'd50,  8'd0,   8'd0,   1'b0};
        vecs[5] = '{1'b0,  51,   0,   0, 8'd51,  8'd0,   8'd0,   1'b1};
        vecs[6] = '{1'b0, 255, 128,   1, 8'd255, 8'd128, 8'd1,   1'b1};
        vecs[7] = '{1'b0,   0, 256, 255, 8'd0,   8'd255, 8'd255, 1'b1};
        vecs[8] = '{1'b1, 256,   0, 255, 8'd0,   8'd255, 8'd1,   1'b1};
        vecs[9] = '{1'b1,   0, 256, 255, 8'd255, 8'd0,   8'd1,   1'b1};

        rst = 1'b1; an = 1'b0; sync_i = 1'b0; r_i = 1'b0; g_i = 1'b0; b_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rcolor", rcolor_o, 0);
        check("reset_gcolor", gcolor_o, 0);
        check("reset_bcolor", bcolor_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_changed", changed_o, 0);
        check("reset_locked", locked_o, 0);
        rst = 1'b0;

        // Back-to-back aligned frames from the vector table.
        for (int v = 0; v < 10; v++) begin
            drive_frame(1'b1, vecs[v].an, vecs[v].rd, vecs[v].gd, vecs[v].bd, 256,
                        1'b1, vecs[v].er, vecs[v].eg, vecs[v].eb, vecs[v].chg);
        end

        // Lock loss: one frame without sync. Last table window still reports.
        drive_frame(1'b0, 1'b1, 0, 256, 255, 256, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        check("lockloss_locked", locked_o, 0);
        check("lockloss_hold_r", rcolor_o, 255);
        check("lockloss_hold_g", gcolor_o, 0);
        check("lockloss_hold_b", bcolor_o, 1);
        // Resync: lock returns only with this window's valid_o.
        drive_frame(1'b1, 1'b1, 0, 256, 255, 256, 1'b1, 8'd255, 8'd0, 8'd1, 1'b0);
        check("resync_still_unlocked", locked_o, 0);

        // Misaligned sync 37 clocks into a window: that window is aborted.
        drive_frame(1'b1, 1'b0, 200, 30, 77, 37, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        drive_frame(1'b1, 1'b0, 200, 30, 77, 256, 1'b1, 8'd200, 8'd30, 8'd77, 1'b1);

        // Async reset with the window counter at 120.
        drive_frame(1'b1, 1'b0, 10, 20, 30, 122, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_rcolor", rcolor_o, 0);
        check("midrst_gcolor", gcolor_o, 0);
        check("midrst_bcolor", bcolor_o, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_changed", changed_o, 0);
        check("midrst_locked", locked_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // No sync yet: nothing may be reported. Then two aligned frames.
        drive_frame(1'b0, 1'b0, 10, 20, 30, 100, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        check("post_reset_locked", locked_o, 0);
        drive_frame(1'b1, 1'b0, 10, 20, 30, 256, 1'b1, 8'd10, 8'd20, 8'd30, 1'b1);
        drive_frame(1'b1, 1'b0, 10, 20, 30, 256, 1'b1, 8'd10, 8'd20, 8'd30, 1'b0);
        drive_frame(1'b0, 1'b0, 0, 0, 0, 10, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
